// File: rtl/fios_pkg.sv
// Shared types and constants for the FIOS Montgomery datapath and its final subtraction stage.
package fios_pkg;

    localparam int WORD_WIDTH = 17;

    typedef logic [WORD_WIDTH-1:0] word_t;

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } fs_state_e;

endpackage : fios_pkg

// File: rtl/fios_sub_word.sv
// One digit of a serial subtractor: {borrow_o, diff_o} = a_i - b_i - borrow_i.
module fios_sub_word #(
    parameter int WIDTH = fios_pkg::WORD_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             borrow_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o
);

    // The extra top bit of the widened difference is the borrow-out.
    always_comb begin
        {borrow_o, diff_o} = {1'b0, a_i} - {1'b0, b_i} - {{WIDTH{1'b0}}, borrow_i};
    end

endmodule : fios_sub_word

// File: rtl/fios_final_sub.sv
// Word-serial final conditional subtraction after the FIOS chain: buffers R and R-p, streams the reduced result.
// Optional overrun detection on digits arriving during the drain: define FINAL_SUB_OVERRUN_CHK_EN.
module fios_final_sub #(
    parameter int WORD_WIDTH = fios_pkg::WORD_WIDTH,
    parameter int NUM_WORDS  = 8
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  res_valid_i,
    input  logic [WORD_WIDTH-1:0] res_i,
    input  logic [WORD_WIDTH-1:0] p_i,
    input  logic                  res_carry_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [WORD_WIDTH-1:0] out_word_o,
    output logic                  out_last_o,
    output logic                  subtracted_o,
`ifdef FINAL_SUB_OVERRUN_CHK_EN
    output logic                  overrun_o,
`endif
    output logic                  busy_o
);

    import fios_pkg::*;

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    fs_state_e             state_q;
    logic [IDX_W-1:0]      k_q;
    logic [IDX_W-1:0]      rd_q;
    logic                  borrow_q;
    logic                  sel_q;
    logic                  out_valid_q;
    logic [WORD_WIDTH-1:0] out_word_q;
    logic                  out_last_q;
    logic                  subtracted_q;
    logic                  busy_q;

    logic [WORD_WIDTH-1:0] res_buf_q [NUM_WORDS];
    logic [WORD_WIDTH-1:0] dif_buf_q [NUM_WORDS];

    logic                  accept_s;
    logic                  borrow_in_s;
    logic [WORD_WIDTH-1:0] dif_s;
    logic                  borrow_out_s;
    logic [IDX_W-1:0]      load_idx_d;
    logic                  load_sel_d;
    logic [WORD_WIDTH-1:0] load_word_d;

    assign accept_s    = (state_q == COLLECT) && res_valid_i;
    assign borrow_in_s = (k_q == '0) ? 1'b0 : borrow_q;

    fios_sub_word #(
        .WIDTH (WORD_WIDTH)
    ) u_sub_word (
        .a_i      (res_i),
        .b_i      (p_i),
        .borrow_i (borrow_in_s),
        .diff_o   (dif_s),
        .borrow_o (borrow_out_s)
    );

    // Next digit to present: digit 0 with the fresh select when the drain starts, else rd+1.
    always_comb begin
        load_idx_d = '0;
        load_sel_d = sel_q;
        if (state_q == COLLECT) begin
            load_idx_d = '0;
            load_sel_d = res_carry_i | ~borrow_out_s;
        end else begin
            load_idx_d = rd_q + IDX_W'(1);
            load_sel_d = sel_q;
        end
        load_word_d = load_sel_d ? dif_buf_q[load_idx_d] : res_buf_q[load_idx_d];
    end

    // Operand buffers carry no reset; they are only read after a full operand was written.
    always_ff @(posedge clock_i) begin
        if (accept_s) begin
            res_buf_q[k_q] <= res_i;
            dif_buf_q[k_q] <= dif_s;
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= COLLECT;
            k_q          <= '0;
            rd_q         <= '0;
            borrow_q     <= 1'b0;
            sel_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            out_word_q   <= '0;
            out_last_q   <= 1'b0;
            subtracted_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (res_valid_i) begin
                        borrow_q <= borrow_out_s;
                        if (k_q == LAST_IDX) begin
                            k_q          <= '0;
                            rd_q         <= '0;
                            sel_q        <= load_sel_d;
                            state_q      <= DRAIN;
                            out_valid_q  <= 1'b1;
                            out_word_q   <= load_word_d;
                            out_last_q   <= 1'b0;
                            subtracted_q <= load_sel_d;
                            busy_q       <= 1'b1;
                        end else begin
                            k_q <= k_q + IDX_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready_i) begin
                        if (rd_q == LAST_IDX) begin
                            rd_q         <= '0;
                            sel_q        <= 1'b0;
                            state_q      <= COLLECT;
                            out_valid_q  <= 1'b0;
                            out_word_q   <= '0;
                            out_last_q   <= 1'b0;
                            subtracted_q <= 1'b0;
                            busy_q       <= 1'b0;
                        end else begin
                            rd_q       <= load_idx_d;
                            out_word_q <= load_word_d;
                            out_last_q <= (load_idx_d == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state_q <= COLLECT;
                end
            endcase
        end
    end

    assign out_valid_o  = out_valid_q;
    assign out_word_o   = out_word_q;
    assign out_last_o   = out_last_q;
    assign subtracted_o = subtracted_q;
    assign busy_o       = busy_q;

`ifdef FINAL_SUB_OVERRUN_CHK_EN
    logic overrun_q;

    // Sticky flag: a digit arrived while the buffers were being drained.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            overrun_q <= 1'b0;
        end else if ((state_q == DRAIN) && res_valid_i) begin
            overrun_q <= 1'b1;
        end else begin
            overrun_q <= overrun_q;
        end
    end

    assign overrun_o = overrun_q;

`ifndef SYNTHESIS
    a_no_overrun : assert property (@(posedge clock_i) disable iff (reset_i)
        !((state_q == DRAIN) && res_valid_i))
        else $error("fios_final_sub: result digit dropped during drain");
`endif
`endif

endmodule : fios_final_sub

// File: tb/tb_fios_final_sub.sv
// Self-checking bench for fios_final_sub (NUM_WORDS=2): vector table plus hand-written multi-cycle sequences.
module tb_fios_final_sub;
    import fios_pkg::*;

    localparam int NW = 2;
    localparam int WW = WORD_WIDTH;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          res_valid_i;
    logic [WW-1:0] res_i;
    logic [WW-1:0] p_i;
    logic          res_carry_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [WW-1:0] out_word_o;
    logic          out_last_o;
    logic          subtracted_o;
    logic          busy_o;
`ifdef FINAL_SUB_OVERRUN_CHK_EN
    logic          overrun_o;
`endif

    always #5 clk = ~clk;

    fios_final_sub #(
        .WORD_WIDTH (WW),
        .NUM_WORDS  (NW)
    ) dut (
        .clock_i      (clk),
        .reset_i      (reset_i),
        .res_valid_i  (res_valid_i),
        .res_i        (res_i),
        .p_i          (p_i),
        .res_carry_i  (res_carry_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_word_o   (out_word_o),
        .out_last_o   (out_last_o),
        .subtracted_o (subtracted_o),
`ifdef FINAL_SUB_OVERRUN_CHK_EN
        .overrun_o    (overrun_o),
`endif
        .busy_o       (busy_o)
    );

    typedef struct {
        logic [WW-1:0] r0;
        logic [WW-1:0] r1;
        logic [WW-1:0] p0;
        logic [WW-1:0] p1;
        logic          c;
        logic [WW-1:0] e0;
        logic [WW-1:0] e1;
        logic          es;
    } vec_t;

    typedef struct packed {
        logic [WW-1:0] word;
        logic          last;
        logic          sub;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2*WW:0] model(input logic [2*WW-1:0] r, input logic [2*WW-1:0] pp,
                                            input logic c);
        if (c || (r >= pp)) begin
            return {1'b1, r - pp};
        end
        return {1'b0, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: compare on every handshake, check gating when idle.
    always @(negedge clk) begin
        if (!reset_i) begin
            if (out_valid_o && out_ready_i) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_output", 32'd1, 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("out_word", 32'(out_word_o), 32'(mon_e.word));
                    check("out_last", 32'(out_last_o), 32'(mon_e.last));
                    check("subtracted", 32'(subtracted_o), 32'(mon_e.sub));
                end
            end else if (!out_valid_o) begin
                check("idle_word_gated", 32'(out_word_o), 32'd0);
            end
        end
    end

    task automatic send_op(input vec_t v);
        sb_q.push_back('{word: v.e0, last: 1'b0, sub: v.es});
        sb_q.push_back('{word: v.e1, last: 1'b1, sub: v.es});
        tick();
        res_valid_i = 1'b1; res_i = v.r0; p_i = v.p0; res_carry_i = 1'b0;
        tick();
        res_i = v.r1; p_i = v.p1; res_carry_i = v.c;
        tick();
        res_valid_i = 1'b0; res_i = '0; p_i = '0; res_carry_i = 1'b0;
        check("first_valid_latency", 32'(out_valid_o), 32'd1);
        check("busy_in_drain", 32'(busy_o), 32'd1);
    endtask

    task automatic wait_idle();
        int cnt = 0;
        while (busy_o && (cnt < 20)) begin
            tick();
            cnt++;
        end
        check("drain_done", 32'(busy_o), 32'd0);
    endtask

    vec_t vecs[6];
    vec_t v2;

    initial begin
        logic [63:0]     rnd_r;
        logic [63:0]     rnd_p;
        logic [2*WW:0]   m;
        logic [2*WW-1:0] rr;
        logic [2*WW-1:0] pp;

        vecs[0] = '{17'h00000, 17'h00002, 17'h1FFFF, 17'h00001, 1'b0, 17'h00001, 17'h00000, 1'b1};
        vecs[1] = '{17'h1FFFE, 17'h00001, 17'h1FFFF, 17'h00001, 1'b0, 17'h1FFFE, 17'h00001, 1'b0};
        vecs[2] = '{17'h1FFFF, 17'h00001, 17'h1FFFF, 17'h00001, 1'b0, 17'h00000, 17'h00000, 1'b1};
        vecs[3] = '{17'h00000, 17'h00000, 17'h1FFFF, 17'h00001, 1'b1, 17'h00001, 17'h1FFFE, 1'b1};
        for (int i = 4; i < 6; i++) begin
            rnd_r = {$urandom(), $urandom()};
            rnd_p = {$urandom(), $urandom()};
            rr = rnd_r[2*WW-1:0];
            pp = rnd_p[2*WW-1:0] | {1'b1, {(2*WW-1){1'b0}}};
            if (i == 5) rr = rr >> 3;
            m = model(rr, pp, (i == 5) ? 1'b1 : 1'b0);
            vecs[i] = '{rr[WW-1:0], rr[2*WW-1:WW], pp[WW-1:0], pp[2*WW-1:WW], (i == 5) ? 1'b1 : 1'b0,
                        m[WW-1:0], m[2*WW-1:WW], m[2*WW]};
        end
        v2 = vecs[1];

        reset_i = 1'b1; res_valid_i = 1'b0; res_i = '0; p_i = '0; res_carry_i = 1'b0;
        out_ready_i = 1'b1;
        tick();
        tick();
        check("rst_valid", 32'(out_valid_o), 32'd0);
        check("rst_word", 32'(out_word_o), 32'd0);
        check("rst_last", 32'(out_last_o), 32'd0);
        check("rst_sub", 32'(subtracted_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        reset_i = 1'b0;

        // Table: back-to-back stream with ready held high.
        for (int i = 0; i < 6; i++) begin
            send_op(vecs[i]);
            tick();
            check("last_on_second_digit", 32'(out_last_o), 32'd1);
            tick();
            check("collect_reentered", 32'(busy_o), 32'd0);
        end

        // Backpressure with a digit arriving mid-drain.
        out_ready_i = 1'b0;
        send_op(vecs[0]);
        for (int c = 0; c < 3; c++) begin
            check("stall_word", 32'(out_word_o), 32'h00001);
            check("stall_last", 32'(out_last_o), 32'd0);
            check("stall_sub", 32'(subtracted_o), 32'd1);
            check("stall_valid", 32'(out_valid_o), 32'd1);
            res_valid_i = (c == 1) ? 1'b1 : 1'b0;
            res_i       = 17'h0ABCD;
            p_i         = 17'h01234;
            tick();
        end
        res_valid_i = 1'b0; res_i = '0; p_i = '0;
        out_ready_i = 1'b1;
        wait_idle();
`ifdef FINAL_SUB_OVERRUN_CHK_EN
        check("overrun_flag", 32'(overrun_o), 32'd1);
`endif
        send_op(v2);
        wait_idle();

        // Reset after the first input digit discards the partial operand.
        tick();
        res_valid_i = 1'b1; res_i = 17'h12345; p_i = 17'h00777;
        tick();
        res_valid_i = 1'b0; res_i = '0; p_i = '0;
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        send_op(v2);
        wait_idle();

        // Asynchronous reset in the middle of a stalled drain.
        out_ready_i = 1'b0;
        send_op(vecs[3]);
        #2;
        reset_i = 1'b1;
        #1;
        check("async_rst_valid", 32'(out_valid_o), 32'd0);
        check("async_rst_word", 32'(out_word_o), 32'd0);
        check("async_rst_sub", 32'(subtracted_o), 32'd0);
        check("async_rst_busy", 32'(busy_o), 32'd0);
        sb_q.delete();
        tick();
        reset_i = 1'b0;
        out_ready_i = 1'b1;
        send_op(v2);
        wait_idle();

        tick();
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fios_final_sub
